// File: rtl/radix_converter.sv
// Sequential binary-to-radix converter: restoring division by BASE, one quotient
// bit per cycle, one digit per pass, with leading-zero blanking and overflow.
module radix_converter #(
    parameter int unsigned BIT_DEPTH  = 16,
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned BASE       = 10
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [BIT_DEPTH-1:0]    number,
    input  logic                    blank_leading,
    output logic                    ready,
    output logic                    valid,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    overflow
);

    localparam int unsigned W     = BIT_DEPTH + 4;
    localparam int unsigned DW    = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(BIT_DEPTH);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_STORE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    if (BASE < 2 || BASE > 16) begin : g_bad_base
        $error("radix_converter: BASE must be in 2..16");
    end

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic [BIT_DEPTH-1:0]  work_q, work_d;
    logic [W-1:0]          rem_q, rem_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic                  blank_lead_q, blank_lead_d;
    logic [DW-1:0]         digits_q, digits_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic                  ovf_q, ovf_d;

    logic [W-1:0]          trial;
    logic                  qbit;
    logic                  zero_above;
    logic [NUM_DIGITS-1:0] mask_calc;

    // Next-state and datapath; the accumulator is only published on entry to DONE.
    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        valid_d      = valid_q;
        work_d       = work_q;
        rem_d        = rem_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        blank_lead_d = blank_lead_q;
        digits_d     = digits_q;
        mask_d       = mask_q;
        ovf_d        = ovf_q;
        trial        = {rem_q[W-2:0], work_q[BIT_DEPTH-1]};
        qbit         = 1'b0;
        zero_above   = 1'b1;
        mask_calc    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    work_d       = number;
                    blank_lead_d = blank_leading;
                    rem_d        = '0;
                    bit_cnt_d    = '0;
                    idx_d        = '0;
                    acc_d        = '0;
                    valid_d      = 1'b0;
                    ready_d      = 1'b0;
                    state_d      = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (trial >= W'(BASE)) begin
                    rem_d = trial - W'(BASE);
                    qbit  = 1'b1;
                end else begin
                    rem_d = trial;
                end
                work_d = {work_q[BIT_DEPTH-2:0], qbit};
                if (bit_cnt_q == CNT_W'(BIT_DEPTH - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = S_STORE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            S_STORE: begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        acc_d[4*i +: 4] = rem_q[3:0];
                    end
                end
                rem_d = '0;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q < IDX_W'(NUM_DIGITS - 1)) begin
                    state_d = S_DIVIDE;
                end else begin
                    // Blank from the top down while digits stay zero; never blank digit 0.
                    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
                        zero_above   = zero_above & (acc_d[4*i +: 4] == 4'd0);
                        mask_calc[i] = blank_lead_q & zero_above & ~(|work_q);
                    end
                    state_d  = S_DONE;
                    ready_d  = 1'b1;
                    valid_d  = 1'b1;
                    digits_d = acc_d;
                    ovf_d    = |work_q;
                    mask_d   = mask_calc;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            work_q       <= '0;
            rem_q        <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            blank_lead_q <= 1'b0;
            digits_q     <= '0;
            mask_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            work_q       <= work_d;
            rem_q        <= rem_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            blank_lead_q <= blank_lead_d;
            digits_q     <= digits_d;
            mask_q       <= mask_d;
            ovf_q        <= ovf_d;
        end
    end

    assign ready      = ready_q;
    assign valid      = valid_q;
    assign digits     = digits_q;
    assign blank_mask = mask_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_radix_converter.sv
// Directed bench for radix_converter: default instance driven from a vector table,
// plus narrow/base-16/base-2 instances and handshake/reset sequences.
module tb_radix_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic        start, blank;
    logic [15:0] number;
    logic        ready, valid, ovf;
    logic [19:0] digits;
    logic [4:0]  mask;

    logic        s3, b3, r3, v3, o3;
    logic [15:0] n3;
    logic [11:0] d3;
    logic [2:0]  m3;

    logic        s16, b16l, r16, v16, o16;
    logic [15:0] n16;
    logic [19:0] d16;
    logic [4:0]  m16;

    logic        s2, b2l, r2, v2, o2;
    logic [3:0]  n2;
    logic [15:0] d2;
    logic [3:0]  m2;

    radix_converter u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .number(number),
        .blank_leading(blank), .ready(ready), .valid(valid), .digits(digits),
        .blank_mask(mask), .overflow(ovf));

    radix_converter #(.BIT_DEPTH(16), .NUM_DIGITS(3), .BASE(10)) u_nd3 (
        .clk(clk), .reset_n(reset_n), .start(s3), .number(n3),
        .blank_leading(b3), .ready(r3), .valid(v3), .digits(d3),
        .blank_mask(m3), .overflow(o3));

    radix_converter #(.BIT_DEPTH(16), .NUM_DIGITS(5), .BASE(16)) u_b16 (
        .clk(clk), .reset_n(reset_n), .start(s16), .number(n16),
        .blank_leading(b16l), .ready(r16), .valid(v16), .digits(d16),
        .blank_mask(m16), .overflow(o16));

    radix_converter #(.BIT_DEPTH(4), .NUM_DIGITS(4), .BASE(2)) u_b2 (
        .clk(clk), .reset_n(reset_n), .start(s2), .number(n2),
        .blank_leading(b2l), .ready(r2), .valid(v2), .digits(d2),
        .blank_mask(m2), .overflow(o2));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] n;
        logic        b;
        logic [19:0] d;
        logic [4:0]  m;
        logic        o;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Accept on the default instance, then scramble inputs to prove they were captured.
    task automatic do_accept(input logic [15:0] n, input logic b);
        @(negedge clk);
        start = 1'b1; number = n; blank = b;
        @(posedge clk); #1;
        start = 1'b0; number = ~n; blank = ~b;
    endtask

    task automatic wait_valid(input int budget, output int lat, output logic rdy_low);
        lat = 0; rdy_low = 1'b1;
        while (!valid && lat < budget) begin
            if (ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic vsel(input int w);
        case (w)
            1:       return v3;
            2:       return v16;
            default: return v2;
        endcase
    endfunction

    task automatic run_other(input int w, input logic [15:0] n, input logic b, output int lat);
        @(negedge clk);
        case (w)
            1:       begin s3 = 1'b1;  n3 = n;       b3 = b;   end
            2:       begin s16 = 1'b1; n16 = n;      b16l = b; end
            default: begin s2 = 1'b1;  n2 = n[3:0]; b2l = b;  end
        endcase
        @(posedge clk); #1;
        s3 = 1'b0; s16 = 1'b0; s2 = 1'b0;
        n3 = 16'h0; n16 = 16'h0; n2 = 4'h0;
        lat = 0;
        while (!vsel(w) && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int   lat;
        logic rdy_low;

        vecs[0] = '{16'd12345, 1'b0, 20'h12345, 5'b00000, 1'b0};
        vecs[1] = '{16'd42,    1'b1, 20'h00042, 5'b11100, 1'b0};
        vecs[2] = '{16'd0,     1'b1, 20'h00000, 5'b11110, 1'b0};
        vecs[3] = '{16'd65535, 1'b0, 20'h65535, 5'b00000, 1'b0};
        vecs[4] = '{16'd65535, 1'b1, 20'h65535, 5'b00000, 1'b0};
        vecs[5] = '{16'd7,     1'b1, 20'h00007, 5'b11110, 1'b0};
        vecs[6] = '{16'd100,   1'b1, 20'h00100, 5'b11000, 1'b0};
        vecs[7] = '{16'd10000, 1'b1, 20'h10000, 5'b00000, 1'b0};

        reset_n = 1'b0;
        start = 1'b0; number = '0; blank = 1'b0;
        s3 = 1'b0; n3 = '0; b3 = 1'b0;
        s16 = 1'b0; n16 = '0; b16l = 1'b0;
        s2 = 1'b0; n2 = '0; b2l = 1'b0;
        #12;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_digits", 32'(digits), 32'd0);
        check("reset_mask", 32'(mask), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_accept(vecs[i].n, vecs[i].b);
            wait_valid(200, lat, rdy_low);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd85);
            check($sformatf("v%0d_ready_low", i), 32'(rdy_low), 32'd1);
            check($sformatf("v%0d_digits", i), 32'(digits), 32'(vecs[i].d));
            check($sformatf("v%0d_mask", i), 32'(mask), 32'(vecs[i].m));
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].o));
            check($sformatf("v%0d_ready_done", i), 32'(ready), 32'd1);
        end

        // Start pulse mid-conversion is dropped and not queued.
        do_accept(16'd12345, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; number = 16'd999; blank = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(200, lat, rdy_low);
        check("ign_latency", 32'(lat), 32'd75);
        check("ign_digits", 32'(digits), 32'h12345);
        check("ign_mask", 32'(mask), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_queue_valid", 32'(valid), 32'd1);
        check("ign_no_queue_digits", 32'(digits), 32'h12345);

        // Start held high: back-to-back conversions.
        @(negedge clk);
        start = 1'b1; number = 16'd42; blank = 1'b1;
        @(posedge clk); #1;
        check("b2b_valid_drop1", 32'(valid), 32'd0);
        number = 16'd7;
        wait_valid(200, lat, rdy_low);
        check("b2b_latency1", 32'(lat), 32'd85);
        check("b2b_digits1", 32'(digits), 32'h00042);
        check("b2b_mask1", 32'(mask), 32'b11100);
        @(posedge clk); #1;
        check("b2b_valid_drop2", 32'(valid), 32'd0);
        check("b2b_ready_low2", 32'(ready), 32'd0);
        wait_valid(200, lat, rdy_low);
        check("b2b_latency2", 32'(lat), 32'd85);
        check("b2b_digits2", 32'(digits), 32'h00007);
        check("b2b_mask2", 32'(mask), 32'b11110);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b2b_stop_valid", 32'(valid), 32'd1);

        // Other parameterisations.
        run_other(1, 16'd999, 1'b1, lat);
        check("nd3_999_digits", 32'(d3), 32'h999);
        check("nd3_999_ovf", 32'(o3), 32'd0);
        run_other(1, 16'd5, 1'b1, lat);
        check("nd3_5_digits", 32'(d3), 32'h005);
        check("nd3_5_mask", 32'(m3), 32'b110);
        run_other(1, 16'd1234, 1'b1, lat);
        check("nd3_latency", 32'(lat), 32'd51);
        check("nd3_1234_digits", 32'(d3), 32'h234);
        check("nd3_1234_ovf", 32'(o3), 32'd1);
        check("nd3_1234_mask", 32'(m3), 32'b000);

        run_other(2, 16'hBEEF, 1'b0, lat);
        check("b16_latency", 32'(lat), 32'd85);
        check("b16_beef_digits", 32'(d16), 32'h0BEEF);
        check("b16_beef_ovf", 32'(o16), 32'd0);
        check("b16_beef_mask", 32'(m16), 32'd0);
        run_other(2, 16'hFFFF, 1'b1, lat);
        check("b16_ffff_digits", 32'(d16), 32'h0FFFF);
        check("b16_ffff_mask", 32'(m16), 32'b10000);

        run_other(3, 16'h000B, 1'b0, lat);
        check("b2_latency", 32'(lat), 32'd20);
        check("b2_1011_digits", 32'(d2), 32'h1011);
        check("b2_1011_ovf", 32'(o2), 32'd0);
        run_other(3, 16'h0002, 1'b1, lat);
        check("b2_0010_digits", 32'(d2), 32'h0010);
        check("b2_0010_mask", 32'(m2), 32'b1100);

        // Asynchronous reset in the middle of a conversion.
        do_accept(16'd12345, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_digits", 32'(digits), 32'd0);
        check("arst_mask", 32'(mask), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_nd3_ovf", 32'(o3), 32'd0);
        check("arst_nd3_digits", 32'(d3), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_accept(16'd65535, 1'b0);
        wait_valid(200, lat, rdy_low);
        check("post_rst_latency", 32'(lat), 32'd85);
        check("post_rst_digits", 32'(digits), 32'h65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
